// File: rtl/fpdiv_share_arb.sv
// Round-robin arbiter sharing one fpdiv_scalar_r64 among NUM_REQ requesters.
// Exactly one operation is in flight; its result and fflags are routed back to the owner.
module fpdiv_share_arb #(
  parameter int NUM_REQ   = 4,
  parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [NUM_REQ*2-1:0]   req_fp_format_i,
  input  logic [NUM_REQ*64-1:0]  req_opa_i,
  input  logic [NUM_REQ*64-1:0]  req_opb_i,
  input  logic [NUM_REQ*3-1:0]   req_rm_i,
  input  logic [NUM_REQ-1:0]     kill_i,
  output logic [NUM_REQ-1:0]     resp_valid_o,
  input  logic [NUM_REQ-1:0]     resp_ready_i,
  output logic [63:0]            resp_res_o,
  output logic [4:0]             resp_fflags_o,
  output logic                   div_start_valid_o,
  input  logic                   div_start_ready_i,
  output logic                   div_flush_o,
  output logic [1:0]             div_fp_format_o,
  output logic [63:0]            div_opa_o,
  output logic [63:0]            div_opb_o,
  output logic [2:0]             div_rm_o,
  input  logic                   div_finish_valid_i,
  output logic                   div_finish_ready_o,
  input  logic [63:0]            div_res_i,
  input  logic [4:0]             div_fflags_i,
  output logic [31:0]            ops_done_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t               state;
  logic [REQ_IDX_W-1:0] rr_ptr;
  logic [REQ_IDX_W-1:0] owner;
  logic [REQ_IDX_W-1:0] owner_next;
  logic [REQ_IDX_W-1:0] winner;
  logic                 any_valid;
  logic                 kill_owner;
  logic                 finish_hs;
  logic [1:0]           fmt_q;
  logic [63:0]          opa_q;
  logic [63:0]          opb_q;
  logic [2:0]           rm_q;
  logic [31:0]          ops_done;

  // Search upward from rr_ptr, wrapping, for the first valid requester.
  always_comb begin : pick_winner
    int j;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    j         = 0;
    winner    = '0;
    any_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_valid && req_valid_i[j]) begin
        any_valid = 1'b1;
        winner    = REQ_IDX_W'(j);
      end
    end
  end

  assign owner_next = (owner == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : owner + REQ_IDX_W'(1);
  assign kill_owner = kill_i[owner];
  assign finish_hs  = div_finish_valid_i & resp_ready_i[owner];

  // Handshake signals only assert in the state that owns them; everything else is 0.
  always_comb begin
    req_ready_o        = '0;
    resp_valid_o       = '0;
    resp_res_o         = '0;
    resp_fflags_o      = '0;
    div_start_valid_o  = 1'b0;
    div_finish_ready_o = 1'b0;
    div_flush_o        = 1'b0;
    case (state)
      IDLE:  if (any_valid) req_ready_o[winner] = 1'b1;
      ISSUE: div_start_valid_o = ~kill_owner;
      BUSY: begin
        resp_valid_o[owner] = div_finish_valid_i & ~kill_owner;
        // A killed owner drains a finished result, or flushes one still in progress.
        div_finish_ready_o  = kill_owner | resp_ready_i[owner];
        div_flush_o         = kill_owner & ~div_finish_valid_i;
        resp_res_o          = div_res_i;
        resp_fflags_o       = div_fflags_i;
      end
      default: ;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: operand registers are reset too, so the divider bus reads 0 while idle after reset.
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      fmt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      rm_q     <= '0;
      ops_done <= '0;
    end else begin
      case (state)
        IDLE: if (any_valid) begin
          owner <= winner;
          fmt_q <= req_fp_format_i[winner*2 +: 2];
          opa_q <= req_opa_i[winner*64 +: 64];
          opb_q <= req_opb_i[winner*64 +: 64];
          rm_q  <= req_rm_i[winner*3 +: 3];
          state <= ISSUE;
        end
        ISSUE: begin
          if (kill_owner) begin
            rr_ptr <= owner_next;
            state  <= IDLE;
          end else if (div_start_ready_i) begin
            state <= BUSY;
          end
        end
        BUSY: begin
          if (kill_owner) begin
            rr_ptr <= owner_next;
            state  <= IDLE;
          end else if (finish_hs) begin
            ops_done <= ops_done + 32'd1;
            rr_ptr   <= owner_next;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign div_fp_format_o = fmt_q;
  assign div_opa_o       = opa_q;
  assign div_opb_o       = opb_q;
  assign div_rm_o        = rm_q;
  assign ops_done_o      = ops_done;

endmodule

// File: tb/tb_fpdiv_share_arb.sv
// Bench for fpdiv_share_arb: directed scenarios then randomized traffic, with the divider
// and a transaction-level round-robin/ownership model both kept inside the bench.
module tb_fpdiv_share_arb;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, kill, resp_valid, resp_ready;
  logic [N*2-1:0]  req_fmt;
  logic [N*64-1:0] req_opa, req_opb;
  logic [N*3-1:0]  req_rm;
  logic [63:0]     resp_res;
  logic [4:0]      resp_fflags;
  logic            div_start_valid, div_start_ready, div_flush;
  logic [1:0]      div_fmt;
  logic [63:0]     div_opa, div_opb;
  logic [2:0]      div_rm;
  logic            div_finish_valid, div_finish_ready;
  logic [63:0]     div_res;
  logic [4:0]      div_fflags;
  logic [31:0]     ops_done;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          rr_model = 0;
  logic [31:0] exp_ops  = '0;

  always #5 clk = ~clk;

  fpdiv_share_arb #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_fp_format_i(req_fmt), .req_opa_i(req_opa), .req_opb_i(req_opb), .req_rm_i(req_rm),
    .kill_i(kill),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_res_o(resp_res), .resp_fflags_o(resp_fflags),
    .div_start_valid_o(div_start_valid), .div_start_ready_i(div_start_ready),
    .div_flush_o(div_flush), .div_fp_format_o(div_fmt),
    .div_opa_o(div_opa), .div_opb_o(div_opb), .div_rm_o(div_rm),
    .div_finish_valid_i(div_finish_valid), .div_finish_ready_o(div_finish_ready),
    .div_res_i(div_res), .div_fflags_i(div_fflags),
    .ops_done_o(ops_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; kill = '0; resp_ready = '0;
    div_start_ready = 1'b0; div_finish_valid = 1'b0; div_res = '0; div_fflags = '0;
    tick();
    tick();
    rst = 1'b0;
    rr_model = 0;
    exp_ops  = '0;
  endtask

  // Round-robin rule: first valid requester at or above the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++) begin
      if (m[(rr_model + k) % N]) return (rr_model + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] others(input int w);
    logic [N-1:0] m;
    m = N'($urandom);
    m[w] = 1'b0;
    return m;
  endfunction

  task automatic set_op(input int i, input logic [1:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [2:0] r);
    req_fmt[i*2 +: 2]  = f;
    req_opa[i*64 +: 64] = a;
    req_opb[i*64 +: 64] = b;
    req_rm[i*3 +: 3]   = r;
  endtask

  task automatic rand_op(input int i);
    set_op(i, 2'($urandom_range(0, 2)), {$urandom, $urandom}, {$urandom, $urandom},
           3'($urandom_range(0, 4)));
  endtask

  // One transaction starting in IDLE at posedge+1. kill_mode: 0 none, 1 kill before finish,
  // 2 kill while finish is valid. The bench plays the divider side.
  task automatic run_op(input int exp_w, input logic [63:0] res, input logic [4:0] ff,
                        input int start_dly, input int lat, input int rdy_dly,
                        input int kill_mode, input bit scramble);
    int w;
    logic [1:0]  f;
    logic [63:0] a, b;
    logic [2:0]  r;
    w = (exp_w >= 0) ? exp_w : pick(req_valid);
    @(negedge clk);
    check("grant", req_ready, 64'(1) << w);
    check("idle_start_valid", div_start_valid, 0);
    check("idle_flush", div_flush, 0);
    check("idle_resp_valid", resp_valid, 0);
    f = req_fmt[w*2 +: 2]; a = req_opa[w*64 +: 64]; b = req_opb[w*64 +: 64]; r = req_rm[w*3 +: 3];
    tick();
    if (scramble) rand_op(w);
    for (int d = 0; d <= start_dly; d++) begin
      div_start_ready = (d == start_dly);
      kill = others(w);
      @(negedge clk);
      check("start_valid", div_start_valid, 1);
      check("div_opa", div_opa, a);
      check("div_opb", div_opb, b);
      check("div_fmt", div_fmt, f);
      check("div_rm", div_rm, r);
      check("issue_req_ready", req_ready, 0);
      tick();
    end
    div_start_ready = 1'b0;
    for (int l = 0; l < lat; l++) begin
      kill = others(w);
      resp_ready = N'($urandom);
      @(negedge clk);
      check("wait_resp_valid", resp_valid, 0);
      check("wait_finish_ready", div_finish_ready, resp_ready[w]);
      check("wait_flush", div_flush, 0);
      check("busy_start_valid", div_start_valid, 0);
      tick();
    end
    resp_ready = '0;
    if (kill_mode == 1) begin
      kill = others(w);
      kill[w] = 1'b1;
      @(negedge clk);
      check("kill_flush", div_flush, 1);
      check("kill_resp_valid", resp_valid, 0);
      tick();
      kill = '0;
      rr_model = (w + 1) % N;
      check("kill_ops_done", ops_done, exp_ops);
      return;
    end
    div_finish_valid = 1'b1;
    div_res = res;
    div_fflags = ff;
    if (kill_mode == 2) begin
      kill = others(w);
      kill[w] = 1'b1;
      @(negedge clk);
      check("drop_resp_valid", resp_valid, 0);
      check("drop_finish_ready", div_finish_ready, 1);
      check("drop_flush", div_flush, 0);
      tick();
      kill = '0;
      div_finish_valid = 1'b0;
      rr_model = (w + 1) % N;
      check("drop_ops_done", ops_done, exp_ops);
      return;
    end
    for (int k = 0; k <= rdy_dly; k++) begin
      resp_ready = N'($urandom);
      resp_ready[w] = (k == rdy_dly);
      kill = others(w);
      @(negedge clk);
      check("resp_valid", resp_valid, 64'(1) << w);
      check("resp_res", resp_res, res);
      check("resp_fflags", resp_fflags, ff);
      check("finish_ready", div_finish_ready, (k == rdy_dly));
      tick();
    end
    div_finish_valid = 1'b0;
    resp_ready = '0;
    kill = '0;
    exp_ops++;
    rr_model = (w + 1) % N;
    check("ops_done", ops_done, exp_ops);
  endtask

  initial begin
    rst = 1'b1;
    req_fmt = '0; req_opa = '0; req_opb = '0; req_rm = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_start_valid", div_start_valid, 0);
    check("rst_finish_ready", div_finish_ready, 0);
    check("rst_flush", div_flush, 0);
    check("rst_ops_done", ops_done, 0);
    check("rst_div_opa", div_opa, 0);
    tick();

    // Single fp64 divide from requester 0
    set_op(0, 2'd2, 64'h3FF0000000000000, 64'h4000000000000000, 3'd0);
    req_valid = 4'b0001;
    run_op(0, 64'h3FE0000000000000, 5'b00000, 0, 3, 0, 0, 0);
    req_valid = '0;
    check("single_ops_done", ops_done, 1);

    // Requesters 1 and 3 contend from reset: order 1,3,1,3
    do_reset();
    set_op(1, 2'd1, 64'h40C00000, 64'h40400000, 3'd0);
    set_op(3, 2'd1, 64'h3F800000, 64'h00000000, 3'd0);
    req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) run_op(1, 64'h40000000, 5'b00000, 1, 2, 1, 0, 0);
      else            run_op(3, 64'h7F800000, 5'b01000, 0, 1, 0, 0, 0);
    end
    req_valid = '0;

    // All four continuously valid: 0,1,2,3,0,1,2,3
    do_reset();
    for (int i = 0; i < N; i++) rand_op(i);
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++)
      run_op(i % N, {$urandom, $urandom}, 5'($urandom), $urandom_range(0, 1),
             $urandom_range(0, 2), $urandom_range(0, 1), 0, 1);
    req_valid = '0;
    check("rr8_ops_done", ops_done, 8);

    // Kill in ISSUE while the divider is ready: no start, back to IDLE
    do_reset();
    rand_op(2);
    req_valid = 4'b0100;
    @(negedge clk);
    check("k2_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    kill = 4'b0100;
    div_start_ready = 1'b1;
    @(negedge clk);
    check("k2_start_valid", div_start_valid, 0);
    tick();
    kill = '0;
    div_start_ready = 1'b0;
    rr_model = 3;
    @(negedge clk);
    check("k2_idle_start_valid", div_start_valid, 0);
    check("k2_resp_valid", resp_valid, 0);
    check("k2_ops_done", ops_done, 0);
    tick();
    req_valid = 4'b0100;
    run_op(2, 64'h1234, 5'b00001, 0, 1, 0, 0, 0);
    req_valid = '0;

    // Kill in BUSY before finish: one-cycle flush, then a clean req1 f16 op
    do_reset();
    rand_op(0);
    req_valid = 4'b0001;
    @(negedge clk);
    check("k0_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    div_start_ready = 1'b1;
    tick();
    div_start_ready = 1'b0;
    kill = 4'b0010;
    @(negedge clk);
    check("k0_nonowner_flush", div_flush, 0);
    tick();
    kill = 4'b0001;
    @(negedge clk);
    check("k0_flush", div_flush, 1);
    check("k0_resp_valid", resp_valid, 0);
    tick();
    kill = '0;
    rr_model = 1;
    @(negedge clk);
    check("k0_flush_off", div_flush, 0);
    check("k0_ops_done", ops_done, 0);
    tick();
    set_op(1, 2'd0, 64'h3C00, 64'h4000, 3'd0);
    req_valid = 4'b0010;
    run_op(1, 64'h3800, 5'b00000, 0, 2, 0, 0, 0);
    req_valid = '0;

    // Back-pressure for 5 cycles, then reset mid-BUSY
    req_valid = 4'b0001;
    run_op(0, 64'hDEADBEEFCAFEF00D, 5'b00001, 1, 2, 5, 0, 1);
    req_valid = 4'b0001;
    @(negedge clk);
    check("rb_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    div_start_ready = 1'b1;
    tick();
    div_start_ready = 1'b0;
    div_finish_valid = 1'b1;
    div_res = 64'hFFFF0000FFFF0000;
    div_fflags = 5'h1F;
    @(negedge clk);
    check("rb_busy_resp_valid", resp_valid, 4'b0001);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rb_resp_valid", resp_valid, 0);
    check("rb_req_ready", req_ready, 0);
    check("rb_start_valid", div_start_valid, 0);
    check("rb_finish_ready", div_finish_ready, 0);
    check("rb_flush", div_flush, 0);
    check("rb_ops_done", ops_done, 0);
    check("rb_resp_res", resp_res, 0);
    check("rb_div_opa", div_opa, 0);
    tick();
    rst = 1'b0;
    div_finish_valid = 1'b0;
    rr_model = 0;
    exp_ops = '0;

    // Randomized traffic with occasional kills
    for (int i = 0; i < N; i++) rand_op(i);
    for (int t = 0; t < 40; t++) begin
      int sel;
      sel = $urandom_range(0, 9);
      req_valid = N'($urandom_range(1, (1 << N) - 1));
      run_op(-1, {$urandom, $urandom}, 5'($urandom), $urandom_range(0, 2),
             $urandom_range(0, 3), $urandom_range(0, 2),
             (sel == 0) ? 1 : (sel == 1) ? 2 : 0, 1);
    end
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
